commit_stage: RTL and testbench
===============================

// Module: commit_stage
// PURPOSE
// - Stage 6 (final stage) of the in-order pipeline. Consumes stage-5 results from execute.
// - Retires each instruction in order; produces the integer-regfile write port (we6/rdaddr6/wb6)
//   and the CSR write-back port that feed the issue stage.
// - Arbitrates synchronous exceptions, interrupts and xRET; signals trap entry to the CSR file.
// - Raises the pipeline flush, then discards in-flight younger instructions for FLUSH_DEPTH cycles.
// PARAMETERS
// - FLUSH_DEPTH  2   younger instructions discarded after a trap/xRET (0 = no drain, no FLUSH state)
// PORTS
// - clk            in   1   clock, all state on posedge
// - nrst           in   1   asynchronous active-low reset
// - valid5         in   1   stage-5 holds a real instruction
// - we5, rd5       in   1,5   regfile write enable / destination
// - result5        in   32  execute result
// - pc5            in   32  instruction PC
// - csr_we5        in   1   CSR write request
// - csr_addr5      in   12  CSR address
// - csr_wdata5     in   32  CSR write value
// - instruction_addr_misaligned5, illegal_instr5, ecall5, ld_misaligned5, st_misaligned5  in 1 each
// - mret5, sret5, uret5  in 1 each
// - current_mode   in   mode::mode_t  privilege mode from CSR file
// - timer_irq, ext_irq  in 1 each  platform pending lines
// - m_tie, m_eie, s_tie, s_eie, u_tie, u_eie  in 1 each  per-source enables
// - m_gie, s_gie, u_gie  in 1 each  global xIE bits
// - we6, rdaddr6, wb6  out 1,5,32  regfile write port
// - csr_we6, csr_wb_addr, csr_wb  out 1,12,32  CSR write port
// - exception_pending  out 1  one-cycle trap-entry pulse
// - cause          out  32  trap cause, valid with exception_pending
// - pc_exc         out  32  trapping PC
// - m_ret, s_ret, u_ret  out 1 each  one-cycle xRET pulses
// - m_interrupt, s_interrupt, u_interrupt  out 1 each  one-cycle interrupt-taken pulses
// - exception      out  1   flush to scoreboard/frontend; pulses with any trap or xRET
// - flushing       out  1   high while in FLUSH
// BEHAVIOUR
// - Timing: every output is registered. Latency is 1 cycle from stage-5 inputs.
// - Reset: every output is 0; FSM = RUN; drain counter = 0.
//   Reset mid-FLUSH returns to RUN with nothing pending.
// - Normal retire (RUN, valid5, no trap, no xRET):
//   - we6 = we5 & (rd5 != 0); rdaddr6 = rd5; wb6 = result5.
//   - csr_we6 = csr_we5; csr_wb_addr = csr_addr5; csr_wb = csr_wdata5.
// - Interrupt eligibility (RUN and valid5 only):
//   - M: (mode<M | m_gie) & ((timer_irq&m_tie) | (ext_irq&m_eie)).
//   - S: mode<=S & (mode<S | s_gie).
//   - U: mode==U & u_gie.
// - Interrupt priority: M ext > M tmr > S ext > S tmr > U ext > U tmr.
// - Interrupt causes: 0x8000_000B / 0x8000_0007 / 0x8000_0009 / 0x8000_0005 / 0x8000_0008 / 0x8000_0004.
// - Exception priority: illegal (2) > instr misaligned (0) > ecall > ld misaligned (4) > st misaligned (6).
// - ecall cause: 8 in U, 9 in S, 11 in M.
// - Trap taken (interrupt or exception): we6 = 0, csr_we6 = 0; exception_pending = 1;
//   cause as above; pc_exc = pc5; exception = 1; matching x_interrupt pulse for interrupts.
// - Simultaneous events:
//   - Interrupt beats exception on the same instruction; that instruction is not retired.
//   - Exception beats xRET.
//   - xRET: x_ret pulse, exception = 1, no regfile or CSR write.
// - FSM RUN -> FLUSH on trap or xRET when FLUSH_DEPTH > 0.
//   - Counter loads FLUSH_DEPTH and decrements once per cycle.
//   - FLUSH -> RUN when counter reaches 1.
// - In FLUSH: stage-5 content is discarded. No writes, no traps, no pulses; interrupts are not sampled.
// - valid5 = 0 in RUN: all write enables and pulses are 0. No interrupt is taken without a valid instruction.
// - Pulses never last more than one cycle, including back-to-back traps.
// STRUCTURE
// - commit_pkg holds:
//   - state enum {RUN, FLUSH};
//   - cause constants CAUSE_ILLEGAL, CAUSE_IADDR_MIS, CAUSE_ECALL_U/S/M, CAUSE_LD_MIS,
//     CAUSE_ST_MIS and the six interrupt causes;
//   - INTR_BIT = 32'h8000_0000.
// - One sub-module, trap_arbiter: combinational priority and cause selection that returns
//   {take_irq, take_exc, cause, irq_level}. The FSM and output registers stay in commit_stage.
// TESTING
// - Retire: valid5, we5, rd5=5, result5=0xDEAD_BEEF -> next cycle we6=1, rdaddr6=5, wb6=0xDEAD_BEEF; rd5=0 -> we6=0.
// - Ecall: ecall5 in M-mode, pc5=0x100 -> exception_pending=1, cause=11, pc_exc=0x100, we6=0;
//   the next 2 valid5 instructions produce no writes; the 3rd retires.
// - Priority: illegal5 + ld_misaligned5 -> cause=2; add timer_irq & m_tie & m_gie in M-mode
//   -> cause=0x8000_0007, m_interrupt=1.
// - Gating: S-mode, ext_irq & m_eie, m_gie=0 -> M interrupt taken (mode<M).
//   M-mode, s_eie & s_gie -> no S interrupt.
// - mret5 with csr_we5 -> m_ret=1, exception=1, csr_we6=0, flushing=1 for 2 cycles.
// - Reset: nrst low during FLUSH -> all outputs 0; first valid5 after release retires normally.

Source files
------------

// File: rtl/commit_pkg.sv
// Privilege-mode and commit-stage shared types: FSM states, trap causes and
// the arbiter/output bundles exchanged between commit_stage and trap_arbiter.
package mode;
    typedef enum logic [1:0] {
        U = 2'b00,
        S = 2'b01,
        M = 2'b11
    } mode_t;
endpackage

package commit_pkg;
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] INTR_BIT        = 32'h8000_0000;

    localparam logic [31:0] CAUSE_IADDR_MIS = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_LD_MIS    = 32'd4;
    localparam logic [31:0] CAUSE_ST_MIS    = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_U   = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_S   = 32'd9;
    localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;

    localparam logic [31:0] CAUSE_U_TMR     = INTR_BIT | 32'd4;
    localparam logic [31:0] CAUSE_S_TMR     = INTR_BIT | 32'd5;
    localparam logic [31:0] CAUSE_M_TMR     = INTR_BIT | 32'd7;
    localparam logic [31:0] CAUSE_U_EXT     = INTR_BIT | 32'd8;
    localparam logic [31:0] CAUSE_S_EXT     = INTR_BIT | 32'd9;
    localparam logic [31:0] CAUSE_M_EXT     = INTR_BIT | 32'd11;

    typedef struct packed {
        logic        take_irq;
        logic        take_exc;
        logic [31:0] cause;
        mode::mode_t irq_level;
    } trap_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rdaddr;
        logic [31:0] wb;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wb;
        logic        exc_pending;
        logic [31:0] cause;
        logic [31:0] pc_exc;
        logic        m_ret;
        logic        s_ret;
        logic        u_ret;
        logic        m_irq;
        logic        s_irq;
        logic        u_irq;
        logic        exception;
    } commit_out_t;

    function automatic logic [31:0] ecall_cause(input mode::mode_t m);
        case (m)
            mode::U: ecall_cause = CAUSE_ECALL_U;
            mode::S: ecall_cause = CAUSE_ECALL_S;
            default: ecall_cause = CAUSE_ECALL_M;
        endcase
    endfunction
endpackage

// File: rtl/commit_stage_trap_arbiter.sv
// Combinational trap arbitration: picks the highest-priority enabled
// interrupt, otherwise the highest-priority synchronous exception.
module trap_arbiter
    import commit_pkg::*;
(
    input  mode::mode_t current_mode,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        m_tie,
    input  logic        m_eie,
    input  logic        s_tie,
    input  logic        s_eie,
    input  logic        u_tie,
    input  logic        u_eie,
    input  logic        m_gie,
    input  logic        s_gie,
    input  logic        u_gie,
    input  logic        illegal_instr,
    input  logic        instr_misaligned,
    input  logic        ecall,
    input  logic        ld_misaligned,
    input  logic        st_misaligned,
    output trap_t       trap
);
    logic [1:0] lvl;
    logic       m_ok, s_ok, u_ok;
    logic       m_ext, m_tmr, s_ext, s_tmr, u_ext, u_tmr;

    // A level is open when running below it, or at it with its global enable set
    assign lvl   = current_mode;
    assign m_ok  = (lvl < mode::M) | m_gie;
    assign s_ok  = (lvl <= mode::S) & ((lvl < mode::S) | s_gie);
    assign u_ok  = (lvl == mode::U) & u_gie;

    assign m_ext = m_ok & ext_irq   & m_eie;
    assign m_tmr = m_ok & timer_irq & m_tie;
    assign s_ext = s_ok & ext_irq   & s_eie;
    assign s_tmr = s_ok & timer_irq & s_tie;
    assign u_ext = u_ok & ext_irq   & u_eie;
    assign u_tmr = u_ok & timer_irq & u_tie;

    always_comb begin
        trap           = '0;
        trap.irq_level = mode::U;
        if (m_ext) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_M_EXT;
            trap.irq_level = mode::M;
        end else if (m_tmr) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_M_TMR;
            trap.irq_level = mode::M;
        end else if (s_ext) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_S_EXT;
            trap.irq_level = mode::S;
        end else if (s_tmr) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_S_TMR;
            trap.irq_level = mode::S;
        end else if (u_ext) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_U_EXT;
        end else if (u_tmr) begin
            trap.take_irq  = 1'b1;
            trap.cause     = CAUSE_U_TMR;
        end else if (illegal_instr) begin
            trap.take_exc  = 1'b1;
            trap.cause     = CAUSE_ILLEGAL;
        end else if (instr_misaligned) begin
            trap.take_exc  = 1'b1;
            trap.cause     = CAUSE_IADDR_MIS;
        end else if (ecall) begin
            trap.take_exc  = 1'b1;
            trap.cause     = ecall_cause(current_mode);
        end else if (ld_misaligned) begin
            trap.take_exc  = 1'b1;
            trap.cause     = CAUSE_LD_MIS;
        end else if (st_misaligned) begin
            trap.take_exc  = 1'b1;
            trap.cause     = CAUSE_ST_MIS;
        end
    end
endmodule

// File: rtl/commit_stage.sv
// Final pipeline stage: in-order retire, trap/xRET arbitration and the
// post-redirect drain of younger instructions. All outputs are registered.
module commit_stage
    import commit_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        valid5,
    input  logic        we5,
    input  logic [4:0]  rd5,
    input  logic [31:0] result5,
    input  logic [31:0] pc5,
    input  logic        csr_we5,
    input  logic [11:0] csr_addr5,
    input  logic [31:0] csr_wdata5,
    input  logic        instruction_addr_misaligned5,
    input  logic        illegal_instr5,
    input  logic        ecall5,
    input  logic        ld_misaligned5,
    input  logic        st_misaligned5,
    input  logic        mret5,
    input  logic        sret5,
    input  logic        uret5,
    input  mode::mode_t current_mode,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        m_tie,
    input  logic        m_eie,
    input  logic        s_tie,
    input  logic        s_eie,
    input  logic        u_tie,
    input  logic        u_eie,
    input  logic        m_gie,
    input  logic        s_gie,
    input  logic        u_gie,
    output logic        we6,
    output logic [4:0]  rdaddr6,
    output logic [31:0] wb6,
    output logic        csr_we6,
    output logic [11:0] csr_wb_addr,
    output logic [31:0] csr_wb,
    output logic        exception_pending,
    output logic [31:0] cause,
    output logic [31:0] pc_exc,
    output logic        m_ret,
    output logic        s_ret,
    output logic        u_ret,
    output logic        m_interrupt,
    output logic        s_interrupt,
    output logic        u_interrupt,
    output logic        exception,
    output logic        flushing
);
    localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    commit_out_t out_q, out_d;
    trap_t       trap;
    logic        redirect;

    trap_arbiter u_trap_arbiter (
        .current_mode     (current_mode),
        .timer_irq        (timer_irq),
        .ext_irq          (ext_irq),
        .m_tie            (m_tie),
        .m_eie            (m_eie),
        .s_tie            (s_tie),
        .s_eie            (s_eie),
        .u_tie            (u_tie),
        .u_eie            (u_eie),
        .m_gie            (m_gie),
        .s_gie            (s_gie),
        .u_gie            (u_gie),
        .illegal_instr    (illegal_instr5),
        .instr_misaligned (instruction_addr_misaligned5),
        .ecall            (ecall5),
        .ld_misaligned    (ld_misaligned5),
        .st_misaligned    (st_misaligned5),
        .trap             (trap)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = '0;
        redirect = 1'b0;
        case (state_q)
            RUN: begin
                if (valid5) begin
                    if (trap.take_irq || trap.take_exc) begin
                        redirect          = 1'b1;
                        out_d.exc_pending = 1'b1;
                        out_d.cause       = trap.cause;
                        out_d.pc_exc      = pc5;
                        out_d.exception   = 1'b1;
                        out_d.m_irq       = trap.take_irq && (trap.irq_level == mode::M);
                        out_d.s_irq       = trap.take_irq && (trap.irq_level == mode::S);
                        out_d.u_irq       = trap.take_irq && (trap.irq_level == mode::U);
                    end else if (mret5 || sret5 || uret5) begin
                        redirect        = 1'b1;
                        out_d.m_ret     = mret5;
                        out_d.s_ret     = !mret5 && sret5;
                        out_d.u_ret     = !mret5 && !sret5 && uret5;
                        out_d.exception = 1'b1;
                    end else begin
                        out_d.we       = we5 && (rd5 != 5'd0);
                        out_d.rdaddr   = rd5;
                        out_d.wb       = result5;
                        out_d.csr_we   = csr_we5;
                        out_d.csr_addr = csr_addr5;
                        out_d.csr_wb   = csr_wdata5;
                    end
                end
                if (redirect && (FLUSH_DEPTH > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(FLUSH_DEPTH);
                end
            end
            FLUSH: begin
                // Younger instructions fetched before the redirect are dropped here
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign we6               = out_q.we;
    assign rdaddr6           = out_q.rdaddr;
    assign wb6               = out_q.wb;
    assign csr_we6           = out_q.csr_we;
    assign csr_wb_addr       = out_q.csr_addr;
    assign csr_wb            = out_q.csr_wb;
    assign exception_pending = out_q.exc_pending;
    assign cause             = out_q.cause;
    assign pc_exc            = out_q.pc_exc;
    assign m_ret             = out_q.m_ret;
    assign s_ret             = out_q.s_ret;
    assign u_ret             = out_q.u_ret;
    assign m_interrupt       = out_q.m_irq;
    assign s_interrupt       = out_q.s_irq;
    assign u_interrupt       = out_q.u_irq;
    assign exception         = out_q.exception;
    assign flushing          = (state_q == FLUSH);
endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios plus a randomized
// run compared cycle by cycle against a privilege-level reference model.
module tb_commit_stage;
    localparam int FLUSH_DEPTH = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        valid5, we5, csr_we5;
    logic [4:0]  rd5;
    logic [31:0] result5, pc5, csr_wdata5;
    logic [11:0] csr_addr5;
    logic        instruction_addr_misaligned5, illegal_instr5, ecall5, ld_misaligned5, st_misaligned5;
    logic        mret5, sret5, uret5;
    mode::mode_t current_mode;
    logic        timer_irq, ext_irq, m_tie, m_eie, s_tie, s_eie, u_tie, u_eie, m_gie, s_gie, u_gie;
    logic        we6, csr_we6, exception_pending, m_ret, s_ret, u_ret;
    logic        m_interrupt, s_interrupt, u_interrupt, exception, flushing;
    logic [4:0]  rdaddr6;
    logic [31:0] wb6, csr_wb, cause, pc_exc;
    logic [11:0] csr_wb_addr;

    int checks = 0;
    int errors = 0;
    int flush_left = 0;

    logic        e_we, e_cwe, e_pend, e_mret, e_sret, e_uret, e_mi, e_si, e_ui, e_exc, e_flush;
    logic [4:0]  e_rd;
    logic [31:0] e_wb, e_cwb, e_cause, e_pc;
    logic [11:0] e_caddr;

    always #5 clk = ~clk;

    commit_stage #(.FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .rd5(rd5), .result5(result5),
        .pc5(pc5), .csr_we5(csr_we5), .csr_addr5(csr_addr5), .csr_wdata5(csr_wdata5),
        .instruction_addr_misaligned5(instruction_addr_misaligned5),
        .illegal_instr5(illegal_instr5), .ecall5(ecall5), .ld_misaligned5(ld_misaligned5),
        .st_misaligned5(st_misaligned5), .mret5(mret5), .sret5(sret5), .uret5(uret5),
        .current_mode(current_mode), .timer_irq(timer_irq), .ext_irq(ext_irq),
        .m_tie(m_tie), .m_eie(m_eie), .s_tie(s_tie), .s_eie(s_eie), .u_tie(u_tie), .u_eie(u_eie),
        .m_gie(m_gie), .s_gie(s_gie), .u_gie(u_gie),
        .we6(we6), .rdaddr6(rdaddr6), .wb6(wb6), .csr_we6(csr_we6), .csr_wb_addr(csr_wb_addr),
        .csr_wb(csr_wb), .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
        .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret), .m_interrupt(m_interrupt),
        .s_interrupt(s_interrupt), .u_interrupt(u_interrupt), .exception(exception),
        .flushing(flushing)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid5 = 0; we5 = 0; rd5 = 0; result5 = 0; pc5 = 0;
        csr_we5 = 0; csr_addr5 = 0; csr_wdata5 = 0;
        instruction_addr_misaligned5 = 0; illegal_instr5 = 0; ecall5 = 0;
        ld_misaligned5 = 0; st_misaligned5 = 0; mret5 = 0; sret5 = 0; uret5 = 0;
        current_mode = mode::M; timer_irq = 0; ext_irq = 0;
        m_tie = 0; m_eie = 0; s_tie = 0; s_eie = 0; u_tie = 0; u_eie = 0;
        m_gie = 0; s_gie = 0; u_gie = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 0;
        tick();
        nrst = 1;
        flush_left = 0;
    endtask

    function automatic bit lvl_bit(input int lvl, input bit bm, input bit bs, input bit bu);
        return (lvl == 3) ? bm : (lvl == 1) ? bs : bu;
    endfunction

    // Reference model: privilege levels walked top-down, external before timer,
    // cause code = level + 8 (external) or level + 4 (timer)
    task automatic model_step();
        int  m;
        int  lv[3] = '{3, 1, 0};
        bit  taken;
        {e_we, e_cwe, e_pend, e_mret, e_sret, e_uret, e_mi, e_si, e_ui, e_exc} = '0;
        e_rd = 0; e_wb = 0; e_cwb = 0; e_cause = 0; e_pc = 0; e_caddr = 0;
        taken = 0;
        m = int'(current_mode);
        if (flush_left > 0) begin
            flush_left--;
        end else if (valid5) begin
            for (int i = 0; i < 3; i++) begin
                bit open;
                open = (m < lv[i]) || (m == lv[i] && lvl_bit(lv[i], m_gie, s_gie, u_gie));
                if (!taken && open) begin
                    if (ext_irq && lvl_bit(lv[i], m_eie, s_eie, u_eie)) begin
                        taken = 1; e_cause = 32'h8000_0000 + 32'(lv[i] + 8);
                    end else if (timer_irq && lvl_bit(lv[i], m_tie, s_tie, u_tie)) begin
                        taken = 1; e_cause = 32'h8000_0000 + 32'(lv[i] + 4);
                    end
                    if (taken) begin
                        e_mi = (lv[i] == 3); e_si = (lv[i] == 1); e_ui = (lv[i] == 0);
                    end
                end
            end
            if (!taken) begin
                taken = 1;
                if (illegal_instr5) e_cause = 2;
                else if (instruction_addr_misaligned5) e_cause = 0;
                else if (ecall5) e_cause = 32'(8 + m);
                else if (ld_misaligned5) e_cause = 4;
                else if (st_misaligned5) e_cause = 6;
                else taken = 0;
            end
            if (taken) begin
                e_pend = 1; e_pc = pc5; e_exc = 1; flush_left = FLUSH_DEPTH;
            end else if (mret5 || sret5 || uret5) begin
                e_mret = mret5; e_sret = !mret5 && sret5; e_uret = !mret5 && !sret5 && uret5;
                e_exc = 1; flush_left = FLUSH_DEPTH;
            end else begin
                e_we = we5 && (rd5 != 0); e_rd = rd5; e_wb = result5;
                e_cwe = csr_we5; e_caddr = csr_addr5; e_cwb = csr_wdata5;
            end
        end
        e_flush = (flush_left > 0);
    endtask

    task automatic test_reset();
        clear_inputs();
        nrst = 0;
        #3;
        checks++;
        if ({we6, csr_we6, exception_pending, exception, flushing, m_ret, m_interrupt} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0", {we6, csr_we6, exception_pending, exception, flushing, m_ret, m_interrupt});
        end
        checks++;
        if ({cause, pc_exc, wb6} !== 96'b0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {cause, pc_exc, wb6});
        end
        tick();
        nrst = 1;
    endtask

    task automatic test_retire();
        do_reset();
        valid5 = 1; we5 = 1; rd5 = 5; result5 = 32'hDEAD_BEEF;
        csr_we5 = 1; csr_addr5 = 12'h305; csr_wdata5 = 32'h1234_5678;
        tick();
        checks++;
        if ({we6, rdaddr6, wb6} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL retire_write got %h exp %h", {we6, rdaddr6, wb6}, {1'b1, 5'd5, 32'hDEAD_BEEF});
        end
        checks++;
        if ({csr_we6, csr_wb_addr, csr_wb} !== {1'b1, 12'h305, 32'h1234_5678}) begin
            errors++; $display("FAIL retire_csr got %h exp %h", {csr_we6, csr_wb_addr, csr_wb}, {1'b1, 12'h305, 32'h1234_5678});
        end
        rd5 = 0;
        tick();
        checks++;
        if (we6 !== 1'b0) begin
            errors++; $display("FAIL retire_x0 got %b exp 0", we6);
        end
    endtask

    task automatic test_ecall();
        do_reset();
        valid5 = 1; ecall5 = 1; pc5 = 32'h100; we5 = 1; rd5 = 7;
        tick();
        checks++;
        if ({exception_pending, cause, pc_exc, we6, exception, flushing} !== {1'b1, 32'd11, 32'h100, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ecall_trap got pend=%b cause=%h pc=%h we=%b", exception_pending, cause, pc_exc, we6);
        end
        ecall5 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({we6, exception_pending, exception} !== 3'b0) begin
                errors++; $display("FAIL ecall_drain%0d got %b exp 000", i, {we6, exception_pending, exception});
            end
        end
        tick();
        checks++;
        if ({we6, rdaddr6, flushing} !== {1'b1, 5'd7, 1'b0}) begin
            errors++; $display("FAIL ecall_resume got %h exp %h", {we6, rdaddr6, flushing}, {1'b1, 5'd7, 1'b0});
        end
    endtask

    task automatic test_priority();
        do_reset();
        valid5 = 1; we5 = 1; rd5 = 3; illegal_instr5 = 1; ld_misaligned5 = 1;
        tick();
        checks++;
        if ({exception_pending, cause} !== {1'b1, 32'd2}) begin
            errors++; $display("FAIL prio_exc got %h exp %h", {exception_pending, cause}, {1'b1, 32'd2});
        end
        valid5 = 0;
        tick(); tick();
        valid5 = 1; timer_irq = 1; m_tie = 1; m_gie = 1; pc5 = 32'h200;
        tick();
        checks++;
        if ({m_interrupt, cause, pc_exc, we6} !== {1'b1, 32'h8000_0007, 32'h200, 1'b0}) begin
            errors++; $display("FAIL prio_irq got mi=%b cause=%h pc=%h we=%b", m_interrupt, cause, pc_exc, we6);
        end
        tick();
        checks++;
        if ({m_interrupt, exception_pending} !== 2'b0) begin
            errors++; $display("FAIL prio_pulse got %b exp 00", {m_interrupt, exception_pending});
        end
    endtask

    task automatic test_gating();
        do_reset();
        valid5 = 0; current_mode = mode::S; ext_irq = 1; m_eie = 1;
        tick();
        checks++;
        if ({m_interrupt, exception_pending} !== 2'b0) begin
            errors++; $display("FAIL gate_novalid got %b exp 00", {m_interrupt, exception_pending});
        end
        valid5 = 1;
        tick();
        checks++;
        if ({m_interrupt, cause} !== {1'b1, 32'h8000_000B}) begin
            errors++; $display("FAIL gate_m_from_s got %h exp %h", {m_interrupt, cause}, {1'b1, 32'h8000_000B});
        end
        valid5 = 0;
        tick(); tick();
        valid5 = 1; we5 = 1; rd5 = 4; current_mode = mode::M; m_eie = 0; s_eie = 1; s_gie = 1;
        tick();
        checks++;
        if ({s_interrupt, exception_pending, we6} !== 3'b001) begin
            errors++; $display("FAIL gate_s_in_m got %b exp 001", {s_interrupt, exception_pending, we6});
        end
    endtask

    task automatic test_mret();
        do_reset();
        valid5 = 1; mret5 = 1; csr_we5 = 1; we5 = 1; rd5 = 3;
        tick();
        checks++;
        if ({m_ret, exception, csr_we6, we6, flushing} !== 5'b11001) begin
            errors++; $display("FAIL mret_pulse got %b exp 11001", {m_ret, exception, csr_we6, we6, flushing});
        end
        mret5 = 0;
        tick();
        checks++;
        if ({m_ret, exception, flushing} !== 3'b001) begin
            errors++; $display("FAIL mret_flush2 got %b exp 001", {m_ret, exception, flushing});
        end
        tick();
        checks++;
        if (flushing !== 1'b0) begin
            errors++; $display("FAIL mret_flush_end got %b exp 0", flushing);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        valid5 = 1; ecall5 = 1;
        tick();
        ecall5 = 0; nrst = 0;
        #2;
        checks++;
        if ({flushing, exception_pending, exception, we6, cause} !== 36'b0) begin
            errors++; $display("FAIL rst_flush got %h exp 0", {flushing, exception_pending, exception, we6, cause});
        end
        tick();
        nrst = 1; we5 = 1; rd5 = 9; result5 = 32'h55;
        tick();
        checks++;
        if ({we6, rdaddr6, wb6} !== {1'b1, 5'd9, 32'h55}) begin
            errors++; $display("FAIL rst_resume got %h exp %h", {we6, rdaddr6, wb6}, {1'b1, 5'd9, 32'h55});
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            valid5 = ($urandom_range(0, 9) < 8);
            we5 = $urandom_range(0, 1); rd5 = 5'($urandom_range(0, 31));
            result5 = $urandom; pc5 = $urandom;
            csr_we5 = $urandom_range(0, 1); csr_addr5 = 12'($urandom); csr_wdata5 = $urandom;
            illegal_instr5 = ($urandom_range(0, 11) == 0);
            instruction_addr_misaligned5 = ($urandom_range(0, 11) == 0);
            ecall5 = ($urandom_range(0, 11) == 0);
            ld_misaligned5 = ($urandom_range(0, 11) == 0);
            st_misaligned5 = ($urandom_range(0, 11) == 0);
            mret5 = ($urandom_range(0, 15) == 0);
            sret5 = ($urandom_range(0, 15) == 0);
            uret5 = ($urandom_range(0, 15) == 0);
            k = $urandom_range(0, 2);
            current_mode = (k == 0) ? mode::U : (k == 1) ? mode::S : mode::M;
            timer_irq = ($urandom_range(0, 3) == 0); ext_irq = ($urandom_range(0, 3) == 0);
            {m_tie, m_eie, s_tie, s_eie, u_tie, u_eie} = 6'($urandom);
            {m_gie, s_gie, u_gie} = 3'($urandom);
            model_step();
            tick();
            checks++;
            if ({we6, rdaddr6, wb6, csr_we6, csr_wb_addr, csr_wb, exception_pending, cause, pc_exc,
                 m_ret, s_ret, u_ret, m_interrupt, s_interrupt, u_interrupt, exception, flushing}
                !== {e_we, e_rd, e_wb, e_cwe, e_caddr, e_cwb, e_pend, e_cause, e_pc,
                     e_mret, e_sret, e_uret, e_mi, e_si, e_ui, e_exc, e_flush}) begin
                errors++;
                $display("FAIL random_cycle%0d got we=%b rd=%0d wb=%h cwe=%b pend=%b cause=%h pc=%h ret=%b%b%b irq=%b%b%b exc=%b fl=%b exp we=%b rd=%0d wb=%h cwe=%b pend=%b cause=%h pc=%h ret=%b%b%b irq=%b%b%b exc=%b fl=%b",
                         c, we6, rdaddr6, wb6, csr_we6, exception_pending, cause, pc_exc, m_ret, s_ret, u_ret,
                         m_interrupt, s_interrupt, u_interrupt, exception, flushing,
                         e_we, e_rd, e_wb, e_cwe, e_pend, e_cause, e_pc, e_mret, e_sret, e_uret,
                         e_mi, e_si, e_ui, e_exc, e_flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_retire();
        test_ecall();
        test_priority();
        test_gating();
        test_mret();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
